grex_pulse_tx: RTL and testbench

//  Transmit side of the PULSE_1V8/RESET_1V8 interface. Emits a programmable train
//  of pulses on PULSE_1V8 toward the 1V8 domain and honours RESET_1V8 from the far
//  end as an abort/hold. Used for bring-up and self-test of the pulse-counting path.

---
 rtl/grex_pulse_tx.sv | 132 +++++++++++++
 tb/tb_grex_pulse_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grex_pulse_tx.sv
// Transmit side of the PULSE_1V8/RESET_1V8 interface: programmable pulse-train
// generator with a synchronized far-end abort/hold input.
module grex_pulse_tx #(
   parameter int unsigned CW   = 8,
   parameter int unsigned SYNC = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [CW-1:0] num_pulses,
   input  logic [CW-1:0] high_cyc,
   input  logic [CW-1:0] low_cyc,
   input  logic          RESET_1V8,
   output logic          PULSE_1V8,
   output logic          busy,
   output logic          done,
   output logic          aborted,
   output logic [CW-1:0] sent_count
);

   typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

   state_t          r_state;
   logic [SYNC-1:0] r_sync;
   logic [CW-1:0]   r_num;
   logic [CW-1:0]   r_high;
   logic [CW-1:0]   r_low;
   logic [CW-1:0]   r_phase;
   logic [CW-1:0]   r_count;
   logic            r_pulse;
   logic            r_busy;
   logic            r_done;
   logic            r_aborted;

   logic            w_rst_s;
   logic [CW-1:0]   w_start_high;
   logic [CW-1:0]   w_high_len;
   logic [CW-1:0]   w_low_len;
   logic [CW-1:0]   w_count_inc;

   assign w_rst_s      = r_sync[SYNC-1];
   // Zero-width phases are stretched to one cycle.
   assign w_start_high = (high_cyc == '0) ? CW'(1) : high_cyc;
   assign w_high_len   = (r_high == '0) ? CW'(1) : r_high;
   assign w_low_len    = (r_low == '0) ? CW'(1) : r_low;
   assign w_count_inc  = (r_count < r_num) ? r_count + CW'(1) : r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_sync    <= '0;
         r_num     <= '0;
         r_high    <= '0;
         r_low     <= '0;
         r_phase   <= '0;
         r_count   <= '0;
         r_pulse   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC-2:0], RESET_1V8};
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (start && !w_rst_s) begin
                  r_num   <= num_pulses;
                  r_high  <= high_cyc;
                  r_low   <= low_cyc;
                  r_count <= '0;
                  if (num_pulses == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= ST_HIGH;
                     r_pulse <= 1'b1;
                     r_busy  <= 1'b1;
                     r_phase <= w_start_high;
                  end
               end
            end
            ST_HIGH: begin
               if (w_rst_s) begin
                  r_state   <= ST_IDLE;
                  r_pulse   <= 1'b0;
                  r_busy    <= 1'b0;
                  r_aborted <= 1'b1;
               end else if (r_phase <= CW'(1)) begin
                  r_state <= ST_LOW;
                  r_pulse <= 1'b0;
                  r_count <= w_count_inc;
                  r_phase <= w_low_len;
               end else begin
                  r_phase <= r_phase - CW'(1);
               end
            end
            ST_LOW: begin
               // Abort is tested first so it wins over a coincident end of burst.
               if (w_rst_s) begin
                  r_state   <= ST_IDLE;
                  r_busy    <= 1'b0;
                  r_aborted <= 1'b1;
               end else if (r_phase <= CW'(1)) begin
                  if (r_count == r_num) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_HIGH;
                     r_pulse <= 1'b1;
                     r_phase <= w_high_len;
                  end
               end else begin
                  r_phase <= r_phase - CW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_pulse <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign PULSE_1V8  = r_pulse;
   assign busy       = r_busy;
   assign done       = r_done;
   assign aborted    = r_aborted;
   assign sent_count = r_count;

endmodule

// File: tb/tb_grex_pulse_tx.sv
// Self-checking bench for grex_pulse_tx: per-cycle expected outputs are queued
// from a small burst model when stimulus is applied and popped as the DUT runs.
module tb_grex_pulse_tx;

   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [CW-1:0] num_pulses;
   logic [CW-1:0] high_cyc;
   logic [CW-1:0] low_cyc;
   logic          RESET_1V8;
   logic          PULSE_1V8;
   logic          busy;
   logic          done;
   logic          aborted;
   logic [CW-1:0] sent_count;

   typedef struct {
      logic          pulse;
      logic          busy;
      logic          done;
      logic          aborted;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   grex_pulse_tx #(.CW(CW), .SYNC(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .num_pulses (num_pulses),
      .high_cyc   (high_cyc),
      .low_cyc    (low_cyc),
      .RESET_1V8  (RESET_1V8),
      .PULSE_1V8  (PULSE_1V8),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .sent_count (sent_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic p, input logic b, input logic d, input logic a, input int c);
      exp_t e;
      e.pulse = p; e.busy = b; e.done = d; e.aborted = a; e.cnt = CW'(c);
      q.push_back(e);
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; RESET_1V8 = 1'b0;
      num_pulses = '0; high_cyc = '0; low_cyc = '0;
      tick(); tick();
      n_checks++;
      if ({PULSE_1V8, busy, done, aborted, sent_count} !== '0) begin
         n_fail++;
         $display("FAIL reset outputs got p%b b%b d%b a%b c%0d exp all 0",
                  PULSE_1V8, busy, done, aborted, sent_count);
      end
      reset = 1'b1;
      tick(); tick(); tick();
   endtask

   // Runs one normal burst; the DUT must be idle with RESET_1V8 low and synced.
   task automatic test_burst(input int num, input int h, input int l, input string name);
      int   hl = (h == 0) ? 1 : h;
      int   ll = (l == 0) ? 1 : l;
      int   idx = 0;
      exp_t e;
      q.delete();
      for (int p = 1; p <= num; p++) begin
         for (int k = 0; k < hl; k++) push(1'b1, 1'b1, 1'b0, 1'b0, p - 1);
         for (int k = 0; k < ll; k++) push(1'b0, 1'b1, 1'b0, 1'b0, p);
      end
      push(1'b0, 1'b0, 1'b1, 1'b0, num);
      num_pulses = CW'(num); high_cyc = CW'(h); low_cyc = CW'(l);
      start = 1'b1;
      tick();
      start = 1'b0;
      // Config changes after acceptance must not affect the running burst.
      num_pulses = CW'(num + 7); high_cyc = CW'(h + 3); low_cyc = CW'(l + 5);
      while (q.size() > 0) begin
         e = q.pop_front();
         if (idx == 1) start = 1'b1;
         if (idx == 2) start = 1'b0;
         n_checks++;
         if (PULSE_1V8 !== e.pulse || busy !== e.busy || done !== e.done ||
             aborted !== e.aborted || sent_count !== e.cnt) begin
            n_fail++;
            $display("FAIL %s cyc%0d got p%b b%b d%b a%b c%0d exp p%b b%b d%b a%b c%0d",
                     name, idx, PULSE_1V8, busy, done, aborted, sent_count,
                     e.pulse, e.busy, e.done, e.aborted, e.cnt);
         end
         idx++;
         tick();
      end
      start = 1'b0;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || PULSE_1V8 !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after-done got d%b b%b p%b exp d0 b0 p0", name, done, busy, PULSE_1V8);
      end
      tick();
   endtask

   task automatic test_zero_num();
      num_pulses = '0; high_cyc = 8'd3; low_cyc = 8'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || PULSE_1V8 !== 1'b0 || sent_count !== '0) begin
         n_fail++;
         $display("FAIL zero_num strobe got d%b b%b p%b c%0d exp d1 b0 p0 c0",
                  done, busy, PULSE_1V8, sent_count);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0 || PULSE_1V8 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_num quiet[%0d] got d%b b%b p%b exp 0 0 0", i, done, busy, PULSE_1V8);
         end
      end
   endtask

   task automatic test_abort();
      exp_t e;
      int   idx = 0;
      q.delete();
      // num=4 high=8 low=2: RESET_1V8 raised in cycle t+11 (second HIGH), seen two
      // flops later, acted on at the next edge.
      for (int k = 0; k < 8; k++) push(1'b1, 1'b1, 1'b0, 1'b0, 0);
      for (int k = 0; k < 2; k++) push(1'b0, 1'b1, 1'b0, 1'b0, 1);
      for (int k = 0; k < 3; k++) push(1'b1, 1'b1, 1'b0, 1'b0, 1);
      push(1'b0, 1'b0, 1'b0, 1'b1, 1);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1);
      num_pulses = 8'd4; high_cyc = 8'd8; low_cyc = 8'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (q.size() > 0) begin
         e = q.pop_front();
         if (idx == 10) RESET_1V8 = 1'b1;
         n_checks++;
         if (PULSE_1V8 !== e.pulse || busy !== e.busy || done !== e.done ||
             aborted !== e.aborted || sent_count !== e.cnt) begin
            n_fail++;
            $display("FAIL abort cyc%0d got p%b b%b d%b a%b c%0d exp p%b b%b d%b a%b c%0d",
                     idx, PULSE_1V8, busy, done, aborted, sent_count,
                     e.pulse, e.busy, e.done, e.aborted, e.cnt);
         end
         idx++;
         tick();
      end
      RESET_1V8 = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_abort_vs_done();
      exp_t e;
      int   idx = 0;
      q.delete();
      // rst_s reaches the FSM exactly on the final LOW cycle: abort must win.
      push(1'b1, 1'b1, 1'b0, 1'b0, 0);
      push(1'b0, 1'b1, 1'b0, 1'b0, 1);
      push(1'b0, 1'b0, 1'b0, 1'b1, 1);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1);
      num_pulses = 8'd1; high_cyc = 8'd1; low_cyc = 8'd1;
      start = 1'b1; RESET_1V8 = 1'b1;
      tick();
      start = 1'b0;
      while (q.size() > 0) begin
         e = q.pop_front();
         n_checks++;
         if (PULSE_1V8 !== e.pulse || busy !== e.busy || done !== e.done ||
             aborted !== e.aborted || sent_count !== e.cnt) begin
            n_fail++;
            $display("FAIL abort_vs_done cyc%0d got p%b b%b d%b a%b c%0d exp p%b b%b d%b a%b c%0d",
                     idx, PULSE_1V8, busy, done, aborted, sent_count,
                     e.pulse, e.busy, e.done, e.aborted, e.cnt);
         end
         idx++;
         tick();
      end
      RESET_1V8 = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_hold();
      RESET_1V8 = 1'b1;
      tick(); tick(); tick();
      num_pulses = 8'd2; high_cyc = 8'd1; low_cyc = 8'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (PULSE_1V8 !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_ignore[%0d] got p%b b%b d%b a%b exp 0 0 0 0",
                     i, PULSE_1V8, busy, done, aborted);
         end
         tick();
      end
      RESET_1V8 = 1'b0;
      tick(); tick(); tick();
      test_burst(2, 1, 1, "after_hold");
   endtask

   task automatic test_async_reset();
      int waited = 0;
      num_pulses = 8'd3; high_cyc = 8'd3; low_cyc = 8'd3;
      start = 1'b1;
      tick();
      tick(); tick(); tick(); tick();
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({PULSE_1V8, busy, done, aborted, sent_count} !== '0) begin
         n_fail++;
         $display("FAIL async_reset immediate got p%b b%b d%b a%b c%0d exp all 0",
                  PULSE_1V8, busy, done, aborted, sent_count);
      end
      tick(); tick();
      n_checks++;
      if ({PULSE_1V8, busy, done, aborted, sent_count} !== '0) begin
         n_fail++;
         $display("FAIL async_reset held got p%b b%b d%b a%b c%0d exp all 0",
                  PULSE_1V8, busy, done, aborted, sent_count);
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if (PULSE_1V8 !== 1'b1 || busy !== 1'b1 || sent_count !== '0 || aborted !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset restart got p%b b%b a%b c%0d exp p1 b1 a0 c0",
                  PULSE_1V8, busy, aborted, sent_count);
      end
      start = 1'b0;
      while (done !== 1'b1 && waited < 100) begin
         tick();
         waited++;
      end
      n_checks++;
      if (done !== 1'b1 || sent_count !== 8'd3) begin
         n_fail++;
         $display("FAIL async_reset burst_end got d%b c%0d after %0d cycles exp d1 c3",
                  done, sent_count, waited);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_burst(3, 2, 1, "basic_3_2_1");
      test_zero_num();
      test_burst(2, 0, 0, "zero_width");
      test_burst(1, 5, 3, "single_5_3");
      test_burst(4, 1, 2, "four_1_2");
      test_abort();
      test_abort_vs_done();
      test_hold();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got running exp finished");
      $fatal(1, "watchdog");
   end

endmodule
